// File: rtl/reg_file_sb.sv
// Pipelined-datapath register file: two combinational read ports, one byte-masked
// write port, optional hardwired R0 and write-to-read bypass, plus a per-register scoreboard.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [ADDR_W-1:0]   RsAddr,
    input  logic [ADDR_W-1:0]   RtAddr,
    output logic [DATA_W-1:0]   RegData1,
    output logic [DATA_W-1:0]   RegData2,
    input  logic [ADDR_W-1:0]   WriteReg,
    input  logic                RegWriteEn,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic                IssueEn,
    input  logic [ADDR_W-1:0]   IssueReg,
    output logic                RsBusy,
    output logic                RtBusy,
    output logic [ADDR_W:0]     PendCount
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DATA_W-1:0] wmask;
    logic              wr_ok, iss_ok, inc, dec;
    logic              hit1, hit2, zero1, zero2;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_val,
                                                 input logic [DATA_W-1:0] new_val,
                                                 input logic [DATA_W-1:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wmask = '0;
        for (int i = 0; i < NB; i++) wmask[8*i +: 8] = {8{ByteEn[i]}};
    end

    assign wr_ok  = RegWriteEn && !(ZERO_REG && WriteReg == '0);
    assign iss_ok = IssueEn && !(ZERO_REG && IssueReg == '0);

    // A simultaneous issue to the retiring register keeps the bit set, so no decrement.
    assign inc = iss_ok && !pend[IssueReg];
    assign dec = RegWriteEn && pend[WriteReg] && !(iss_ok && IssueReg == WriteReg);

    // NOTE: the array is reset because the architecture needs every register to read 0
    // after reset; this forces flops rather than a RAM macro, which is fine at this depth.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            // NOTE: non-blocking assignments for all sequential state avoid ordering races.
            regs[WriteReg] <= merge(regs[WriteReg], WriteData, wmask);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend      <= '0;
            PendCount <= '0;
        end else begin
            if (RegWriteEn) pend[WriteReg] <= 1'b0;
            // Later assignment wins: a new producer overrides the retiring one.
            if (iss_ok) pend[IssueReg] <= 1'b1;
            PendCount <= PendCount + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        end
    end

    // Bypass is gated by reset so the ports read 0 while the write path is ignored.
    assign hit1  = BYPASS && Rst_n && RegWriteEn && (RsAddr == WriteReg);
    assign hit2  = BYPASS && Rst_n && RegWriteEn && (RtAddr == WriteReg);
    assign zero1 = ZERO_REG && (RsAddr == '0);
    assign zero2 = ZERO_REG && (RtAddr == '0);

    assign RegData1 = zero1 ? '0 : hit1 ? merge(regs[RsAddr], WriteData, wmask) : regs[RsAddr];
    assign RegData2 = zero2 ? '0 : hit2 ? merge(regs[RtAddr], WriteData, wmask) : regs[RtAddr];

    assign RsBusy = pend[RsAddr] && !hit1 && !zero1;
    assign RtBusy = pend[RtAddr] && !hit2 && !zero2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: bypass and non-bypass instances share stimulus
// and are compared against a behavioural register/scoreboard model.
module tb_reg_file_sb;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [4:0]  rs, rt, wa, ir;
    logic        we, iss;
    logic [31:0] wd;
    logic [3:0]  be;

    logic [31:0] d1_a, d2_a, d1_b, d2_b;
    logic        rsb_a, rtb_a, rsb_b, rtb_b;
    logic [5:0]  pc_a, pc_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_reg  [32];
    bit          m_pend [32];

    always #5 Clk = ~Clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .RsAddr(rs), .RtAddr(rt),
        .RegData1(d1_a), .RegData2(d2_a), .WriteReg(wa), .RegWriteEn(we),
        .WriteData(wd), .ByteEn(be), .IssueEn(iss), .IssueReg(ir),
        .RsBusy(rsb_a), .RtBusy(rtb_a), .PendCount(pc_a)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .RsAddr(rs), .RtAddr(rt),
        .RegData1(d1_b), .RegData2(d2_b), .WriteReg(wa), .RegWriteEn(we),
        .WriteData(wd), .ByteEn(be), .IssueEn(iss), .IssueReg(ir),
        .RsBusy(rsb_b), .RtBusy(rtb_b), .PendCount(pc_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (a == 5'd0 || !Rst_n) return 32'h0;
        v = m_reg[a];
        if (byp && we && a == wa)
            for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0 || !Rst_n) return 32'h0;
        if (byp && we && a == wa) return 32'h0;
        return {31'h0, m_pend[a]};
    endfunction

    function automatic logic [31:0] exp_cnt();
        int c = 0;
        foreach (m_pend[i]) c += int'(m_pend[i]);
        return 32'(c);
    endfunction

    task automatic model_clear();
        foreach (m_reg[i]) m_reg[i] = 32'h0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
    endtask

    task automatic check_comb();
        check("rd1_byp",   d1_a,           exp_rd(rs, 1'b1));
        check("rd2_byp",   d2_a,           exp_rd(rt, 1'b1));
        check("rd1_nobyp", d1_b,           exp_rd(rs, 1'b0));
        check("rd2_nobyp", d2_b,           exp_rd(rt, 1'b0));
        check("rsb_byp",   {31'h0, rsb_a}, exp_busy(rs, 1'b1));
        check("rtb_byp",   {31'h0, rtb_a}, exp_busy(rt, 1'b1));
        check("rsb_nobyp", {31'h0, rsb_b}, exp_busy(rs, 1'b0));
        check("rtb_nobyp", {31'h0, rtb_b}, exp_busy(rt, 1'b0));
    endtask

    // Checks combinational outputs now, applies one clock edge to the model, then checks counts.
    task automatic tick();
        check_comb();
        @(posedge Clk);
        if (Rst_n) begin
            if (we && wa != 5'd0)
                for (int i = 0; i < 4; i++) if (be[i]) m_reg[wa][8*i +: 8] = wd[8*i +: 8];
            if (we) m_pend[wa] = 1'b0;
            if (iss && ir != 5'd0) m_pend[ir] = 1'b1;
        end
        #1;
        check("cnt_byp",   {26'h0, pc_a}, exp_cnt());
        check("cnt_nobyp", {26'h0, pc_b}, exp_cnt());
    endtask

    task automatic cycle();
        #3;
        tick();
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic i, input logic [4:0] r,
                         input logic [4:0] s, input logic [4:0] t);
        we = w; wa = a; wd = d; be = b; iss = i; ir = r; rs = s; rt = t;
    endtask

    initial begin
        model_clear();
        Rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd7);
        #2;
        check_comb();
        check("rst_cnt", {26'h0, pc_a}, 32'h0);
        #10 Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // Full-word write, read back next cycle.
        drive(1'b1, 5'd5, 32'hA5A5A5A5, 4'hF, 1'b0, 5'd0, 5'd1, 5'd2);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        #3;
        check("wr5_rd1", d1_a, 32'hA5A5A5A5);
        check("wr5_rd2", d2_a, 32'h0);
        tick();

        // Partial byte write, then write with all byte enables off.
        drive(1'b1, 5'd5, 32'h0000BEEF, 4'h3, 1'b0, 5'd0, 5'd1, 5'd2);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        #3;
        check("be3_rd1", d1_a, 32'hA5A5BEEF);
        tick();
        drive(1'b1, 5'd5, 32'hFFFFFFFF, 4'h0, 1'b0, 5'd0, 5'd1, 5'd2);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        #3;
        check("be0_rd1", d1_a, 32'hA5A5BEEF);
        tick();

        // Same-cycle write/read: forwarded only by the bypass instance.
        drive(1'b1, 5'd7, 32'h12345678, 4'hF, 1'b0, 5'd0, 5'd7, 5'd0);
        #3;
        check("byp_same",   d1_a, 32'h12345678);
        check("nobyp_same", d1_b, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd7, 5'd0);
        #3;
        check("nobyp_next", d1_b, 32'h12345678);
        tick();

        // Register 0: writes and issues are discarded.
        drive(1'b1, 5'd0, 32'hDEADBEEF, 4'hF, 1'b1, 5'd0, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #3;
        check("r0_rd1", d1_a, 32'h0);
        check("r0_busy", {31'h0, rsb_a}, 32'h0);
        check("r0_cnt", {26'h0, pc_a}, 32'h0);
        tick();

        // Scoreboard: issue 3, issue 9, issue+write 3, write 9.
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 5'd3, 5'd9);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 5'd3, 5'd9);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd3, 5'd9);
        #3;
        check("sb_cnt2", {26'h0, pc_a}, 32'd2);
        check("sb_rs3",  {31'h0, rsb_a}, 32'd1);
        tick();
        drive(1'b1, 5'd3, 32'h33333333, 4'hF, 1'b1, 5'd3, 5'd3, 5'd9);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd3, 5'd9);
        #3;
        check("sb_both_cnt", {26'h0, pc_a}, 32'd2);
        check("sb_both_rs3", {31'h0, rsb_a}, 32'd1);
        tick();
        drive(1'b1, 5'd9, 32'h99999999, 4'hF, 1'b0, 5'd0, 5'd3, 5'd9);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd3, 5'd9);
        #3;
        check("sb_cnt1", {26'h0, pc_a}, 32'd1);
        tick();

        // Asynchronous reset mid-cycle with reg 4 pending and holding 11.
        drive(1'b1, 5'd4, 32'h11, 4'hF, 1'b1, 5'd4, 5'd1, 5'd2);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd4, 5'd4);
        #3;
        check("pre_rst_rd", d1_a, 32'h11);
        check("pre_rst_busy", {31'h0, rsb_a}, 32'd1);
        Rst_n = 1'b0;
        #1;
        model_clear();
        check_comb();
        check("rst_async_cnt", {26'h0, pc_a}, 32'h0);
        check("rst_async_rd",  d1_a, 32'h0);
        drive(1'b1, 5'd4, 32'hFFFF, 4'hF, 1'b1, 5'd4, 5'd4, 5'd4);
        tick();
        #2;
        Rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd4, 5'd4);
        #1;
        check("rst_nowrite_rd", d1_a, 32'h0);
        check("rst_nowrite_busy", {31'h0, rsb_a}, 32'h0);
        tick();

        // Randomized traffic on a small address window to force hits and collisions.
        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom_range(0, 1));
            iss = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 15));
            ir  = 5'($urandom_range(0, 15));
            wd  = $urandom;
            be  = 4'($urandom);
            rs  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 15));
            rt  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 15));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the monocycle MIPS register file, intended for the pipelined datapath.
- Provides two asynchronous read ports and one synchronous write port with byte enables.
- Optional hardwired-zero R0 and write-to-read bypass.
- Integrated scoreboard: one pending bit per register, set when an instruction issues and cleared when its result is written back. The hazard unit uses it to generate stalls.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never pending.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = reads show the array only.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- RsAddr  in  ADDR_W  read port 1 address.
- RtAddr  in  ADDR_W  read port 2 address.
- RegData1  out  DATA_W  read port 1 data (combinational).
- RegData2  out  DATA_W  read port 2 data (combinational).
- WriteReg  in  ADDR_W  write address.
- RegWriteEn  in  1  write enable.
- WriteData  in  DATA_W  write data.
- ByteEn  in  DATA_W/8  per-byte write mask; bit i controls bits [8i+7:8i].
- IssueEn  in  1  mark IssueReg pending.
- IssueReg  in  ADDR_W  destination register of the issuing instruction.
- RsBusy  out  1  RsAddr is pending (combinational).
- RtBusy  out  1  RtAddr is pending (combinational).
- PendCount  out  ADDR_W+1  number of pending registers (registered).

Behaviour:
- Reset (Rst_n low, asynchronous, any time including mid-write):
  - All registers clear to 0.
  - All pending bits clear to 0.
  - PendCount is 0.
  - RegData1/2 read 0; RsBusy/RtBusy are 0.
  - Writes and issues are ignored while Rst_n is low.
- Write: on the rising edge with RegWriteEn=1, reg[WriteReg] byte i takes WriteData byte i wherever ByteEn[i]=1; other bytes hold.
  - ByteEn=0 with RegWriteEn=1: no data change, but the pending bit is still cleared (retire without write).
- Read is combinational: RegData1 = reg[RsAddr], RegData2 = reg[RtAddr].
- Bypass (BYPASS=1): when RegWriteEn=1 and the read address equals WriteReg, the enabled bytes come from WriteData and the remaining bytes from the array.
  - Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- ZERO_REG=1, register 0:
  - Reads return 0 regardless of bypass.
  - Writes are discarded.
  - Issue to register 0 is ignored; RsBusy/RtBusy are never asserted for address 0.
- Scoreboard, per register r at the rising edge:
  - Issue only (IssueEn && IssueReg==r): pend[r] is set to 1.
  - Write only (RegWriteEn && WriteReg==r): pend[r] is cleared to 0.
  - Both on the same r in the same cycle: pend[r] = 1. The old producer retires and the new one is pending.
  - Issue to an already-pending register: stays 1 (no counting of multiple producers).
- Busy outputs:
  - RsBusy = pend[RsAddr]; RtBusy = pend[RtAddr].
  - With BYPASS=1, Busy is masked to 0 when RegWriteEn=1 and the address equals WriteReg in that cycle.
  - Issue in cycle N affects Busy from cycle N+1.
- PendCount:
  - Updated every edge: +1 if the issue sets a bit that was 0; −1 if the write clears a bit that was 1; net 0 if both happen on different registers.
  - Always equals the population count of pend[]. Maximum 2**ADDR_W (2**ADDR_W−1 with ZERO_REG=1); never wraps.
- Undefined-address hazards do not exist; the full address range is valid.

Test Plan:
- Reset, then write A5A5A5A5 to reg 5 with ByteEn=F; read Rs=5 the next cycle -> RegData1=A5A5A5A5, RegData2 (Rt=0)=0.
- Reg 5 = A5A5A5A5; write 0000BEEF with ByteEn=3 -> reg 5 = A5A5BEEF; write with ByteEn=0 -> unchanged.
- BYPASS=1: in the same cycle, write 12345678 to reg 7 with Rs=7 -> RegData1=12345678 before the edge; BYPASS=0 -> old value until after the edge.
- Write DEADBEEF to reg 0 and issue reg 0 -> RegData1 (Rs=0) = 0, RsBusy=0, PendCount=0.
- Issue reg 3 and reg 9 in consecutive cycles -> PendCount=2, RsBusy=1 for Rs=3. Then issue reg 3 and write reg 3 in the same cycle -> pend[3] stays 1, PendCount=2. Then write reg 9 -> PendCount=1.
- With reg 4 pending and holding value 11, assert Rst_n low mid-cycle -> immediately PendCount=0, RegData for reg 4 reads 0, Busy=0. An edge during reset with RegWriteEn=1 writes nothing.
